// File: rtl/tff_pkg.sv
// Shared definitions for the toggle-cell counter family.
package tff_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_UP     = 2'b10,
    MODE_DOWN   = 2'b11
  } mode_e;

endpackage

// File: rtl/tff_cell.sv
// Single toggle flip-flop with synchronous reset value and parallel load.
module tff_cell (
  input  logic clk,
  input  logic reset,
  input  logic rst_val,
  input  logic load,
  input  logic d,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= rst_val;
    else if (load)
      q <= d;
    else if (t)
      q <= ~q;
  end

endmodule

// File: rtl/tff_counter.sv
// WIDTH-bit counter/toggle register built from tff_cell instances, with
// wrap/saturate limits, registered terminal-count pulse and sticky overflow.
module tff_counter
  import tff_pkg::*;
#(
  parameter int unsigned        WIDTH     = 8,
  parameter bit                 SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t_mask,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  mode_e            mode_sel;
  logic [WIDTH-1:0] and_pre;
  logic [WIDTH-1:0] nor_pre;
  logic [WIDTH-1:0] t;
  logic             limit;

  assign mode_sel = mode_e'(mode);

  // and_pre[i] = all bits below i are 1; nor_pre[i] = all bits below i are 0
  always_comb begin
    and_pre    = '0;
    nor_pre    = '0;
    and_pre[0] = 1'b1;
    nor_pre[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      and_pre[i] = and_pre[i-1] & q[i-1];
      nor_pre[i] = nor_pre[i-1] & ~q[i-1];
    end
  end

  assign limit = en & (((mode_sel == MODE_UP) & (&q)) |
                       ((mode_sel == MODE_DOWN) & ~(|q)));

  always_comb begin
    t = '0;
    if (en) begin
      case (mode_sel)
        MODE_TOGGLE: t = t_mask;
        MODE_UP:     t = and_pre;
        MODE_DOWN:   t = nor_pre;
        default:     t = '0;
      endcase
    end
    if (SATURATE && limit)
      t = '0;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk     (clk),
      .reset   (reset),
      .rst_val (RESET_VAL[i]),
      .load    (load),
      .d       (load_val[i]),
      .t       (t[i]),
      .q       (q[i])
    );
  end

  // A limit event sets ovf even when clr_ovf is asserted the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      tc <= limit & ~load;
      if (limit && !load)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tff_counter.sv
// Scoreboard bench: three counter variants share randomized stimulus and are
// compared against an arithmetic reference model.
module tb_tff_counter;

  logic       clk = 1'b0;
  logic       reset, en, load, clr_ovf;
  logic [1:0] mode;
  logic [3:0] t_mask, load_val;

  logic [3:0] q0, q1;
  logic       q2;
  logic       tc0, tc1, tc2, ovf0, ovf1, ovf2;

  always #5 clk = ~clk;

  tff_counter #(.WIDTH(4), .SATURATE(1'b0), .RESET_VAL(4'h5)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .t_mask(t_mask),
    .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
    .q(q0), .tc(tc0), .ovf(ovf0));

  tff_counter #(.WIDTH(4), .SATURATE(1'b1), .RESET_VAL(4'h5)) u_sat (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .t_mask(t_mask),
    .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
    .q(q1), .tc(tc1), .ovf(ovf1));

  tff_counter #(.WIDTH(1), .SATURATE(1'b0), .RESET_VAL(1'b1)) u_bit (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .t_mask(t_mask[0:0]),
    .load(load), .load_val(load_val[0:0]), .clr_ovf(clr_ovf),
    .q(q2), .tc(tc2), .ovf(ovf2));

  typedef struct {
    int q[3];
    bit tc[3];
    bit ovf[3];
  } exp_t;

  exp_t sb[$];

  int widths[3] = '{4, 4, 1};
  bit sats[3]   = '{1'b0, 1'b1, 1'b0};
  int rvals[3]  = '{5, 5, 1};
  int mq[3];
  bit mtc[3];
  bit movf[3];

  int checks = 0;
  int errors = 0;

  // Reference: q+1 / q-1 / xor arithmetic on an integer, limits by value.
  task automatic model_step(input int k, input bit r, input bit ld, input int lv,
                            input bit e, input int md, input int tm, input bit clr);
    int  m;
    bit  lim;
    m   = (1 << widths[k]) - 1;
    lim = 1'b0;
    if (r) begin
      mq[k] = rvals[k]; mtc[k] = 1'b0; movf[k] = 1'b0;
    end else if (ld) begin
      mq[k] = lv & m; mtc[k] = 1'b0;
      if (clr) movf[k] = 1'b0;
    end else begin
      if (e) begin
        case (md)
          1: mq[k] = (mq[k] ^ tm) & m;
          2: begin
            if (mq[k] == m) begin lim = 1'b1; mq[k] = sats[k] ? m : 0; end
            else mq[k] = mq[k] + 1;
          end
          3: begin
            if (mq[k] == 0) begin lim = 1'b1; mq[k] = sats[k] ? 0 : m; end
            else mq[k] = mq[k] - 1;
          end
          default: ;
        endcase
      end
      mtc[k] = lim;
      if (lim) movf[k] = 1'b1;
      else if (clr) movf[k] = 1'b0;
    end
  endtask

  task automatic drive(input bit r, input bit ld, input int lv, input bit e,
                       input int md, input int tm, input bit clr);
    exp_t x;
    @(negedge clk);
    reset = r; load = ld; load_val = 4'(lv); en = e; mode = 2'(md);
    t_mask = 4'(tm); clr_ovf = clr;
    for (int k = 0; k < 3; k++) begin
      model_step(k, r, ld, lv, e, md, tm, clr);
      x.q[k] = mq[k]; x.tc[k] = mtc[k]; x.ovf[k] = movf[k];
    end
    sb.push_back(x);
  endtask

  task automatic chk(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d at %0t: actual=%0d expected=%0d", name, k, $time, act, exp);
    end
  endtask

  // Monitor: every cycle the DUTs present registered outputs after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("q",   0, int'(q0),   x.q[0]);
        chk("tc",  0, int'(tc0),  int'(x.tc[0]));
        chk("ovf", 0, int'(ovf0), int'(x.ovf[0]));
        chk("q",   1, int'(q1),   x.q[1]);
        chk("tc",  1, int'(tc1),  int'(x.tc[1]));
        chk("ovf", 1, int'(ovf1), int'(x.ovf[1]));
        chk("q",   2, int'(q2),   x.q[2]);
        chk("tc",  2, int'(tc2),  int'(x.tc[2]));
        chk("ovf", 2, int'(ovf2), int'(x.ovf[2]));
      end
    end
  end

  initial begin
    int waited;
    reset = 1'b1; en = 1'b0; load = 1'b0; clr_ovf = 1'b0;
    mode = 2'b00; t_mask = '0; load_val = '0;

    // reset held two cycles with other inputs toggling
    drive(1, 1, 3, 1, 2, 15, 0);
    drive(1, 0, 9, 1, 3, 6, 1);
    // UP wrap from E, then clear ovf
    drive(0, 1, 14, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 1, 2, 0, 0);
    drive(0, 0, 0, 0, 2, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    // DOWN from 1 to the lower limit and beyond
    drive(0, 1, 1, 0, 0, 0, 0);
    repeat (4) drive(0, 0, 0, 1, 3, 0, 0);
    // masked toggle
    drive(0, 1, 10, 0, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 1, 1, 3, 0);
    // load beats a limit step; then limit with clr_ovf in the same cycle
    drive(0, 1, 15, 0, 0, 0, 1);
    drive(0, 1, 7, 1, 2, 0, 0);
    drive(0, 1, 15, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 2, 0, 1);
    drive(0, 0, 0, 1, 0, 0, 1);
    // reset on an edge where a wrap would occur
    drive(0, 1, 15, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 2, 0, 0);
    drive(0, 0, 0, 1, 2, 0, 0);

    for (int n = 0; n < 500; n++) begin
      drive(($urandom % 32) == 0, ($urandom % 8) == 0, int'($urandom % 16),
            ($urandom % 4) != 0, int'($urandom % 4), int'($urandom % 16),
            ($urandom % 8) == 0);
    end

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk);
      #3;
      waited++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: actual=%0d pending expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
